// File: rtl/fifo_ensemble_ctrl_if.sv
// Signal bundle between the range-gate FIFO sequencer and its surroundings:
// line trigger/config inputs, FIFO control strobes and status.
`timescale 1ns/1ps
interface fifo_ensemble_ctrl_if #(
  parameter int DEEP  = 4,
  parameter int CNT_W = 8
);
  logic             prfTrig;
  logic             sampleValid;
  logic [DEEP-1:0]  gateCount;
  logic [CNT_W-1:0] replayCount;
  logic [CNT_W-1:0] readDiv;
  logic             fifoWriteNext;
  logic             fifoReadNext;
  logic             fifoGoToReg0;
  logic             fifoReadEnable;
  logic             fifoReset;
  logic             outValid;
  logic             busy;
  logic             done;
  logic             overrunErr;

  modport master (
    input  prfTrig, sampleValid, gateCount, replayCount, readDiv,
    output fifoWriteNext, fifoReadNext, fifoGoToReg0, fifoReadEnable,
           fifoReset, outValid, busy, done, overrunErr
  );

  modport slave (
    output prfTrig, sampleValid, gateCount, replayCount, readDiv,
    input  fifoWriteNext, fifoReadNext, fifoGoToReg0, fifoReadEnable,
           fifoReset, outValid, busy, done, overrunErr
  );
endinterface

// File: rtl/fifo_ensemble_ctrl.sv
// Per-PRF-line sequencer: clears the gate FIFO, fills it with the programmed
// number of samples, then replays them at a divided rate to the demodulator.
`timescale 1ns/1ps
module fifo_ensemble_ctrl #(
  parameter int DEEP  = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  fifo_ensemble_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FILL, S_REWIND, S_READ, S_FINISH
  } state_t;

  localparam logic [DEEP:0]    ONE_C = 1;
  localparam logic [CNT_W-1:0] ONE_N = 1;

  state_t           r_state, w_state_next;
  logic             r_phase, w_phase_next;
  logic [DEEP:0]    r_wr_cnt, w_wr_cnt_next;
  logic [DEEP:0]    r_rd_cnt, w_rd_cnt_next;
  logic [CNT_W-1:0] r_pass_cnt, w_pass_cnt_next;
  logic [CNT_W-1:0] r_div_cnt, w_div_cnt_next;
  logic [DEEP-1:0]  r_gate, w_gate_next;
  logic [CNT_W-1:0] r_replay, w_replay_next;
  logic [CNT_W-1:0] r_div, w_div_next;
  logic             r_err, w_err_next;
  logic             w_fill_wr;

  logic r_wr_stb, r_rd_stb, r_g0_stb, r_rd_en, r_fifo_rst;
  logic r_out_valid, r_busy, r_done;

  logic [DEEP-1:0]  w_gate_clamp;
  logic [CNT_W-1:0] w_replay_clamp;
  logic [CNT_W-1:0] w_div_clamp;
  logic [DEEP:0]    w_gate_ext;
  logic             w_rd_last;
  logic             w_pass_last;
  logic             w_clear0;

  assign w_gate_clamp   = (bus.gateCount == '0) ? DEEP'(1) : bus.gateCount;
  assign w_replay_clamp = (bus.replayCount == '0) ? ONE_N : bus.replayCount;
  assign w_div_clamp    = (bus.readDiv < CNT_W'(2)) ? CNT_W'(2) : bus.readDiv;
  // One extra counter bit so a full-depth count never wraps onto zero.
  assign w_gate_ext     = {1'b0, r_gate};
  assign w_rd_last      = (r_rd_cnt + ONE_C) == w_gate_ext;
  assign w_pass_last    = (r_pass_cnt + ONE_N) == r_replay;

  always_comb begin
    w_state_next    = r_state;
    w_phase_next    = 1'b0;
    w_wr_cnt_next   = r_wr_cnt;
    w_rd_cnt_next   = r_rd_cnt;
    w_pass_cnt_next = r_pass_cnt;
    w_div_cnt_next  = r_div_cnt;
    w_gate_next     = r_gate;
    w_replay_next   = r_replay;
    w_div_next      = r_div;
    w_err_next      = r_err;
    w_fill_wr       = 1'b0;

    if (bus.prfTrig && (r_state != S_IDLE))
      w_err_next = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (bus.prfTrig) begin
          w_state_next    = S_CLEAR;
          w_gate_next     = w_gate_clamp;
          w_replay_next   = w_replay_clamp;
          w_div_next      = w_div_clamp;
          w_wr_cnt_next   = '0;
          w_rd_cnt_next   = '0;
          w_pass_cnt_next = '0;
          w_div_cnt_next  = '0;
        end
      end
      S_CLEAR: begin
        if (!r_phase) begin
          w_phase_next = 1'b1;
        end else begin
          w_state_next  = S_FILL;
          w_wr_cnt_next = '0;
        end
      end
      S_FILL: begin
        // The cycle showing the final write strobe is the last FILL cycle.
        if (r_wr_cnt == w_gate_ext) begin
          w_state_next = S_REWIND;
        end else if (bus.sampleValid) begin
          if (r_wr_stb) begin
            w_err_next = 1'b1;
          end else begin
            w_fill_wr     = 1'b1;
            w_wr_cnt_next = r_wr_cnt + ONE_C;
          end
        end
      end
      S_REWIND: begin
        if (!r_phase) begin
          w_phase_next = 1'b1;
        end else begin
          w_state_next   = S_READ;
          w_rd_cnt_next  = '0;
          w_div_cnt_next = '0;
        end
      end
      S_READ: begin
        if (r_div_cnt == (r_div - ONE_N)) begin
          w_div_cnt_next = '0;
          w_rd_cnt_next  = r_rd_cnt + ONE_C;
          if (w_rd_last) begin
            w_pass_cnt_next = r_pass_cnt + ONE_N;
            w_state_next    = w_pass_last ? S_FINISH : S_REWIND;
          end
        end else begin
          w_div_cnt_next = r_div_cnt + ONE_N;
        end
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state wants to show.
  assign w_clear0 = (w_state_next == S_CLEAR) && !w_phase_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_pass_cnt  <= '0;
      r_div_cnt   <= '0;
      r_gate      <= '0;
      r_replay    <= '0;
      r_div       <= '0;
      r_err       <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_g0_stb    <= 1'b0;
      r_rd_en     <= 1'b0;
      r_fifo_rst  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_wr_cnt    <= w_wr_cnt_next;
      r_rd_cnt    <= w_rd_cnt_next;
      r_pass_cnt  <= w_pass_cnt_next;
      r_div_cnt   <= w_div_cnt_next;
      r_gate      <= w_gate_next;
      r_replay    <= w_replay_next;
      r_div       <= w_div_next;
      r_err       <= w_err_next;
      r_wr_stb    <= w_clear0 || w_fill_wr;
      r_rd_stb    <= (w_state_next == S_READ) && (w_div_cnt_next == ONE_N);
      r_g0_stb    <= (w_state_next == S_REWIND) && !w_phase_next;
      r_rd_en     <= (w_state_next == S_READ);
      r_fifo_rst  <= (w_state_next == S_IDLE) || w_clear0;
      r_out_valid <= (w_state_next == S_READ) && (w_div_cnt_next == '0);
      r_busy      <= (w_state_next != S_IDLE);
      r_done      <= (w_state_next == S_FINISH);
    end
  end

  assign bus.fifoWriteNext  = r_wr_stb;
  assign bus.fifoReadNext   = r_rd_stb;
  assign bus.fifoGoToReg0   = r_g0_stb;
  assign bus.fifoReadEnable = r_rd_en;
  assign bus.fifoReset      = r_fifo_rst;
  assign bus.outValid       = r_out_valid;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.overrunErr     = r_err;
endmodule

// File: tb/tb_fifo_ensemble_ctrl.sv
// Directed bench for fifo_ensemble_ctrl with a behavioural gate FIFO that
// captures the data the demodulator would see on each outValid.
`timescale 1ns/1ps
module tb_fifo_ensemble_ctrl;
  localparam int DEEP  = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  fifo_ensemble_ctrl_if #(.DEEP(DEEP), .CNT_W(CNT_W)) bus ();
  fifo_ensemble_ctrl #(.DEEP(DEEP), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural FIFO: write/read pointers driven by the controller strobes.
  logic [7:0] mem [16];
  logic [3:0] wptr = '0;
  logic [3:0] rptr = '0;
  logic [7:0] din  = '0;
  logic [7:0] fifo_q;
  assign fifo_q = mem[rptr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifoReset) wptr <= '0;
    else if (bus.fifoWriteNext) begin
      mem[wptr] <= din;
      wptr      <= wptr + 4'd1;
    end
    if (bus.fifoGoToReg0) rptr <= '0;
    else if (bus.fifoReadNext) rptr <= rptr + 4'd1;
  end

  // Monitor: cumulative records; the stimulus takes deltas against snapshots.
  int         wr_cyc [$];
  int         ov_cyc [$];
  int         rn_cyc [$];
  logic [7:0] ov_q   [$];
  int   n_g0 = 0, n_done = 0, n_viol = 0, done_cyc = 0;
  logic p_wr = 1'b0, p_rn = 1'b0, p_g0 = 1'b0, p_ov = 1'b0, p_done = 1'b0;

  always @(negedge clk) begin
    if (bus.fifoWriteNext && !bus.fifoReset) wr_cyc.push_back(cyc);
    if (bus.outValid) begin
      ov_q.push_back(fifo_q);
      ov_cyc.push_back(cyc);
    end
    if (bus.fifoReadNext) rn_cyc.push_back(cyc);
    if (bus.fifoGoToReg0) n_g0 <= n_g0 + 1;
    if (bus.done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if ((bus.fifoWriteNext && p_wr) || (bus.fifoReadNext && p_rn) ||
        (bus.fifoGoToReg0 && p_g0) || (bus.outValid && p_ov) || (bus.done && p_done))
      n_viol <= n_viol + 1;
    p_wr   <= bus.fifoWriteNext;
    p_rn   <= bus.fifoReadNext;
    p_g0   <= bus.fifoGoToReg0;
    p_ov   <= bus.outValid;
    p_done <= bus.done;
  end

  logic [7:0] line_data [16];
  int trig_cyc = 0, b_wr = 0, b_ov = 0, b_rn = 0, b_g0 = 0, b_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  function automatic logic [8:0] outs_vec();
    return {bus.fifoReset, bus.busy, bus.done, bus.outValid, bus.fifoWriteNext,
            bus.fifoReadNext, bus.fifoGoToReg0, bus.fifoReadEnable, bus.overrunErr};
  endfunction

  task automatic start_line(input int g, input int r, input int d);
    @(negedge clk);
    bus.gateCount   = DEEP'(g);
    bus.replayCount = CNT_W'(r);
    bus.readDiv     = CNT_W'(d);
    bus.prfTrig     = 1'b1;
    trig_cyc = cyc;
    b_wr = wr_cyc.size(); b_ov = ov_q.size(); b_rn = rn_cyc.size();
    b_g0 = n_g0; b_done = n_done;
    @(negedge clk);
    bus.prfTrig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_samples(input int first, input int n, input logic [7:0] base, input int spacing);
    for (int i = 0; i < n; i++) begin
      din = base + 8'(i);
      line_data[first + i] = din;
      bus.sampleValid = 1'b1;
      @(negedge clk);
      bus.sampleValid = 1'b0;
      repeat (spacing - 1) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name);
    int  base = n_done;
    logic ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (n_done != base) begin ok = 1'b1; break; end
    end
    check({name, ".done_seen"}, 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ov(input string name, input int n);
    logic ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ov_q.size() - b_ov >= n) begin ok = 1'b1; break; end
    end
    check({name, ".ov_reached"}, 32'(ok), 32'd1);
  endtask

  task automatic check_line(input string name, input int g, input int r);
    int ge = (g == 0) ? 1 : g;
    int re = (r == 0) ? 1 : r;
    check({name, ".writes"},  wr_cyc.size() - b_wr, ge);
    check({name, ".ovcount"}, ov_q.size() - b_ov, ge * re);
    check({name, ".goto0"},   n_g0 - b_g0, re);
    check({name, ".done"},    n_done - b_done, 1);
    for (int k = 0; k < ge * re && b_ov + k < ov_q.size(); k++)
      check($sformatf("%s.q%0d", name, k), 32'(ov_q[b_ov + k]), 32'(line_data[k % ge]));
    check({name, ".busy"},  32'(bus.busy), 32'd0);
    check({name, ".viol"},  n_viol, 0);
  endtask

  initial begin
    int v;
    bus.prfTrig = 1'b0; bus.sampleValid = 1'b0;
    bus.gateCount = '0; bus.replayCount = '0; bus.readDiv = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs_vec()), 32'h100);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // Single line 4/1/2 with latency checks.
    start_line(4, 1, 2);
    send_samples(0, 4, 8'hA0, 3);
    wait_done("line1");
    check_line("line1", 4, 1);
    v = (wr_cyc.size() > b_wr) ? wr_cyc[b_wr] - trig_cyc : -1;
    check("line1.trig_to_wr", v, 4);
    v = (wr_cyc.size() > b_wr + 3 && ov_cyc.size() > b_ov) ? ov_cyc[b_ov] - wr_cyc[b_wr + 3] : -1;
    check("line1.wr_to_ov", v, 3);
    v = (ov_cyc.size() > b_ov + 1) ? ov_cyc[b_ov + 1] - ov_cyc[b_ov] : -1;
    check("line1.ov_gap", v, 2);
    check("line1.err", 32'(bus.overrunErr), 32'd0);

    // Replay 3/3/4.
    start_line(3, 3, 4);
    send_samples(0, 3, 8'h00, 3);
    wait_done("replay");
    check_line("replay", 3, 3);
    v = (ov_cyc.size() > b_ov + 1) ? ov_cyc[b_ov + 1] - ov_cyc[b_ov] : -1;
    check("replay.ov_gap", v, 4);

    // Clamping 0/0/0.
    start_line(0, 0, 0);
    send_samples(0, 1, 8'h5A, 3);
    wait_done("clamp");
    check_line("clamp", 0, 0);
    v = (ov_cyc.size() > b_ov && rn_cyc.size() > b_rn) ? rn_cyc[b_rn] - ov_cyc[b_ov] : -1;
    check("clamp.ov_to_rn", v, 1);
    v = (ov_cyc.size() > b_ov) ? done_cyc - ov_cyc[b_ov] : -1;
    check("clamp.ov_to_done", v, 2);

    // Full depth 15/2/2.
    start_line(15, 2, 2);
    send_samples(0, 15, 8'h10, 3);
    wait_done("full");
    check_line("full", 15, 2);
    check("full.err", 32'(bus.overrunErr), 32'd0);

    // Back-to-back sampleValid during FILL: second dropped, error set.
    start_line(3, 1, 2);
    din = 8'h60; line_data[0] = 8'h60;
    bus.sampleValid = 1'b1;
    repeat (2) @(negedge clk);
    bus.sampleValid = 1'b0;
    @(negedge clk);
    send_samples(1, 2, 8'h61, 3);
    wait_done("ovr_fill");
    check_line("ovr_fill", 3, 1);
    check("ovr_fill.err", 32'(bus.overrunErr), 32'd1);
    @(negedge clk); resetN = 1'b0;
    @(negedge clk); resetN = 1'b1;
    repeat (2) @(negedge clk);
    check("err_cleared", 32'(bus.overrunErr), 32'd0);

    // prfTrig during READ is ignored but flagged.
    start_line(3, 2, 3);
    send_samples(0, 3, 8'h30, 3);
    wait_ov("ovr_trig", 1);
    bus.prfTrig = 1'b1;
    @(negedge clk);
    bus.prfTrig = 1'b0;
    wait_done("ovr_trig");
    check_line("ovr_trig", 3, 2);
    check("ovr_trig.err", 32'(bus.overrunErr), 32'd1);

    // Reset in the middle of READ, then a clean line.
    start_line(4, 1, 2);
    send_samples(0, 4, 8'h40, 3);
    wait_ov("midrst", 2);
    resetN = 1'b0;
    #1;
    check("midrst.outs", 32'(outs_vec()), 32'h100);
    @(negedge clk); resetN = 1'b1;
    repeat (2) @(negedge clk);
    start_line(4, 1, 2);
    send_samples(0, 4, 8'h50, 3);
    wait_done("clean");
    check_line("clean", 4, 1);
    check("clean.err", 32'(bus.overrunErr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
